fetch_resp_checker: RTL and testbench
=====================================

# fetch_resp_checker

Passive protocol and data checker that sits on the 128-bit instruction-fetch port between the fetch traffic generator and the icache under test. It tracks every granted request in an in-order outstanding queue, matches each `fetch_rvalid_i` against the oldest pending address, and checks `fetch_rdata_i` against the fill pattern of the L2 pattern model. It also flags handshake violations and exposes saturating transaction and error counters to the bench.

## Interface
- `FETCH_ADDR_WIDTH`, 32, fetch address width.
- `FETCH_DATA_WIDTH`, 128, fetch data width; fixed at 4 × 32-bit words.
- `MAX_OUTSTANDING`, 4, outstanding queue depth; power of two, ≥ 2.
- `TIMEOUT_CYCLES`, 256, response watchdog limit; used only with `FETCH_CHK_TIMEOUT_EN`.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `fetch_req_i` in 1: monitored request.
- `fetch_addr_i` in FETCH_ADDR_WIDTH: monitored address.
- `fetch_gnt_i` in 1: monitored grant.
- `fetch_rvalid_i` in 1: monitored response valid.
- `fetch_rdata_i` in FETCH_DATA_WIDTH: monitored response data.
- `clear_i` in 1: synchronous clear of counters and error state. The queue is not cleared.
- `trans_cnt_o` out 32: completed (popped) transactions; saturating.
- `err_cnt_o` out 32: number of cycles with at least one error; saturating.
- `err_o` out 1: sticky error flag.
- `err_code_o` out 3: code of the first error since reset or clear.
- `last_err_addr_o` out FETCH_ADDR_WIDTH: aligned address involved in the most recent data error.
- `outstanding_o` out $clog2(MAX_OUTSTANDING)+1: current queue occupancy.

## Operation
- **Accept.** `fetch_req_i & fetch_gnt_i` pushes `{fetch_addr_i[W-1:4], 4'b0}` into the queue.
- **Retire.** `fetch_rvalid_i` pops the head entry.
- **Expected data.** For head address A, word k (k = 0..3, k = 0 at the LSBs) is A + 4k, computed modulo 2^32.
- **Error codes:**
  - 0: none
  - 1: DATA_MISMATCH
  - 2: SPURIOUS_RVALID
  - 3: OVERFLOW
  - 4: TIMEOUT
  - 5: REQ_DROP
- **Request FSM** (reset state IDLE):
  - IDLE: on `req & !gnt`, capture the address and go to PEND. Otherwise stay in IDLE.
  - PEND: on `req & gnt` with the same address, go to IDLE. On `req & !gnt` with the same address, stay in PEND. If `!req`, or the address differs from the captured one, raise REQ_DROP and go to IDLE.
- **Simultaneous push and pop:** both happen and occupancy is unchanged.
- **Pop when empty:** raises SPURIOUS_RVALID and no compare is done. A push in the same cycle still happens, because a response can never belong to a same-cycle grant.
- **Push when full:** raises OVERFLOW and the push is dropped. If a pop occurs in the same cycle, the push is accepted and no error is raised.
- **Data mismatch:** raises DATA_MISMATCH and loads `last_err_addr_o` with the head address. The pop still happens.
- **Multiple errors in one cycle:** `err_cnt_o` increments by 1. If the first-error code is still unset, it is taken by priority 2 > 3 > 1 > 5 > 4.
- **`clear_i`:** zeroes both counters, `err_o`, `err_code_o` and `last_err_addr_o`. Events in the clear cycle are ignored for counting. The queue and FSM keep running.

## Timing
- **Reset values:** all outputs are 0, the queue is empty, and the FSM is in IDLE.
- **Latency:** all outputs are registered and reflect an event one cycle after the sampling edge. `outstanding_o` updates one cycle after the push/pop edge.
- **Minimum gnt-to-rvalid spacing:** 1 cycle. An rvalid arriving back-to-back with every grant is legal and produces no error.
- **Counter saturation:** both counters stop at 0xFFFF_FFFF and do not wrap.
- **Queue pointers:** wrap modulo MAX_OUTSTANDING. Occupancy uses one extra bit to distinguish full from empty.
- **Reset mid-transaction:** asynchronous; the queue and counters are discarded immediately.

## Configuration
- **`FETCH_CHK_TIMEOUT_EN` defined:**
  - A cycle counter runs while the queue is non-empty.
  - The counter restarts on each pop and on each push into an empty queue.
  - Reaching TIMEOUT_CYCLES raises TIMEOUT and restarts the counter.
- **`FETCH_CHK_TIMEOUT_EN` undefined:** no watchdog logic is built and code 4 is never produced.

## Test plan
- **Single fetch, correct data.** req+gnt at A=0x0000_0120, rvalid 3 cycles later with rdata=0x0000012C_00000128_00000124_00000120. Required: trans_cnt_o=1, err_o=0, outstanding_o shows 1 and then 0.
- **Data mismatch.** Same as above with word 2 = 0xDEAD_BEEF. Required: err_o=1, err_code_o=1, last_err_addr_o=0x120, err_cnt_o=1, trans_cnt_o=1.
- **Overflow.** 5 grants with no rvalid and MAX_OUTSTANDING=4. Required: err_code_o=3 after the fifth grant, outstanding_o=4. Then push+pop in the same cycle while full: no new error.
- **Spurious response.** rvalid with an empty queue. Required: err_code_o=2. `clear_i` pulse: all outputs return to 0.
- **Request drop.** req without gnt for 2 cycles, then req drops. Required: err_code_o=5. A variant that changes the address while pending: also err_code_o=5.
- **Timeout** (`FETCH_CHK_TIMEOUT_EN`, TIMEOUT_CYCLES=16). One grant with no rvalid for 16 cycles. Required: err_code_o=4. With the macro undefined, no error after 1000 cycles.

Source files
------------

// File: rtl/fetch_resp_checker_if.sv
// rtl/fetch_resp_checker_if.sv - monitored instruction-fetch port bundle
interface fetch_resp_checker_if #(
    parameter int FETCH_ADDR_WIDTH = 32,
    parameter int FETCH_DATA_WIDTH = 128
);
    logic                        fetch_req_i;
    logic [FETCH_ADDR_WIDTH-1:0] fetch_addr_i;
    logic                        fetch_gnt_i;
    logic                        fetch_rvalid_i;
    logic [FETCH_DATA_WIDTH-1:0] fetch_rdata_i;

    modport master (
        output fetch_req_i,
        output fetch_addr_i,
        output fetch_gnt_i,
        output fetch_rvalid_i,
        output fetch_rdata_i
    );

    modport slave (
        input fetch_req_i,
        input fetch_addr_i,
        input fetch_gnt_i,
        input fetch_rvalid_i,
        input fetch_rdata_i
    );
endinterface

// File: rtl/fetch_resp_checker.sv
// rtl/fetch_resp_checker.sv - passive fetch-port protocol/data checker; optional watchdog via FETCH_CHK_TIMEOUT_EN
module fetch_resp_checker #(
    parameter int FETCH_ADDR_WIDTH = 32,
    parameter int FETCH_DATA_WIDTH = 128,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int TIMEOUT_CYCLES   = 256
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    fetch_resp_checker_if.slave                  fetch,
    input  logic                                 clear_i,
    output logic [31:0]                          trans_cnt_o,
    output logic [31:0]                          err_cnt_o,
    output logic                                 err_o,
    output logic [2:0]                           err_code_o,
    output logic [FETCH_ADDR_WIDTH-1:0]          last_err_addr_o,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(MAX_OUTSTANDING);

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_DATA     = 3'd1;
    localparam logic [2:0] CODE_SPURIOUS = 3'd2;
    localparam logic [2:0] CODE_OVERFLOW = 3'd3;
    localparam logic [2:0] CODE_TIMEOUT  = 3'd4;
    localparam logic [2:0] CODE_REQ_DROP = 3'd5;

    typedef enum logic {S_IDLE, S_PEND} state_t;

    logic [FETCH_ADDR_WIDTH-1:0] q_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [OCC_W-1:0]            occ;

    logic                        q_empty;
    logic                        q_full;
    logic                        push_req;
    logic                        do_push;
    logic                        do_pop;
    logic [FETCH_ADDR_WIDTH-1:0] head_addr;
    logic [FETCH_ADDR_WIDTH-1:0] push_addr;
    logic [FETCH_DATA_WIDTH-1:0] exp_data;

    logic                        err_spurious;
    logic                        err_overflow;
    logic                        err_data;
    logic                        err_drop;
    logic                        err_timeout;
    logic                        any_err;
    logic [2:0]                  err_prio_code;

    state_t                      state;
    state_t                      state_nxt;
    logic [FETCH_ADDR_WIDTH-1:0] cap_addr;

    assign q_empty   = (occ == '0);
    assign q_full    = (occ == OCC_FULL);
    assign push_req  = fetch.fetch_req_i & fetch.fetch_gnt_i;
    assign do_pop    = fetch.fetch_rvalid_i & ~q_empty;
    // A same-cycle pop frees a slot, so a push into a full queue is still legal then.
    assign do_push   = push_req & (~q_full | do_pop);
    assign head_addr = q_mem[rd_ptr];
    assign push_addr = {fetch.fetch_addr_i[FETCH_ADDR_WIDTH-1:4], 4'b0000};

    always_comb begin
        exp_data = '0;
        for (int k = 0; k < FETCH_DATA_WIDTH / 32; k++) begin
            exp_data[k*32 +: 32] = 32'(head_addr + FETCH_ADDR_WIDTH'(4 * k));
        end
    end

    assign err_spurious = fetch.fetch_rvalid_i & q_empty;
    assign err_overflow = push_req & q_full & ~do_pop;
    assign err_data     = do_pop & (fetch.fetch_rdata_i != exp_data);

    // Queue storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_mem[wr_ptr] <= push_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Request-hold FSM: a request left ungranted must persist with a stable address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fetch.fetch_req_i && !fetch.fetch_gnt_i) begin
                    state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (!fetch.fetch_req_i || (fetch.fetch_addr_i != cap_addr)) begin
                    state_nxt = S_IDLE;
                end else if (fetch.fetch_gnt_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        err_drop = 1'b0;
        if (state == S_PEND) begin
            err_drop = !fetch.fetch_req_i || (fetch.fetch_addr_i != cap_addr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr <= '0;
        end else if (state == S_IDLE && fetch.fetch_req_i && !fetch.fetch_gnt_i) begin
            cap_addr <= fetch.fetch_addr_i;
        end
    end

`ifdef FETCH_CHK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign err_timeout = ~q_empty & ~do_pop & (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (do_pop || (do_push && q_empty) || err_timeout) begin
            wd_cnt <= '0;
        end else if (!q_empty) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

    assign any_err = err_spurious | err_overflow | err_data | err_drop | err_timeout;

    always_comb begin
        err_prio_code = CODE_NONE;
        if (err_spurious) begin
            err_prio_code = CODE_SPURIOUS;
        end else if (err_overflow) begin
            err_prio_code = CODE_OVERFLOW;
        end else if (err_data) begin
            err_prio_code = CODE_DATA;
        end else if (err_drop) begin
            err_prio_code = CODE_REQ_DROP;
        end else if (err_timeout) begin
            err_prio_code = CODE_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trans_cnt_o     <= '0;
            err_cnt_o       <= '0;
            err_o           <= 1'b0;
            err_code_o      <= CODE_NONE;
            last_err_addr_o <= '0;
        end else if (clear_i) begin
            trans_cnt_o     <= '0;
            err_cnt_o       <= '0;
            err_o           <= 1'b0;
            err_code_o      <= CODE_NONE;
            last_err_addr_o <= '0;
        end else begin
            if (do_pop && trans_cnt_o != '1) begin
                trans_cnt_o <= trans_cnt_o + 1'b1;
            end
            if (any_err) begin
                err_o <= 1'b1;
                if (err_cnt_o != '1) begin
                    err_cnt_o <= err_cnt_o + 1'b1;
                end
                if (err_code_o == CODE_NONE) begin
                    err_code_o <= err_prio_code;
                end
            end
            if (err_data) begin
                last_err_addr_o <= head_addr;
            end
        end
    end

    assign outstanding_o = occ;
endmodule

// File: tb/tb_fetch_resp_checker.sv
// tb/tb_fetch_resp_checker.sv - directed self-checking bench for fetch_resp_checker
`timescale 1ns/1ps
module tb_fetch_resp_checker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_i;
    logic [31:0] trans_cnt_o;
    logic [31:0] err_cnt_o;
    logic        err_o;
    logic [2:0]  err_code_o;
    logic [31:0] last_err_addr_o;
    logic [2:0]  outstanding_o;

    int n_checks = 0;
    int n_errors = 0;

    fetch_resp_checker_if #(.FETCH_ADDR_WIDTH(32), .FETCH_DATA_WIDTH(128)) bus ();

    fetch_resp_checker #(
        .FETCH_ADDR_WIDTH(32),
        .FETCH_DATA_WIDTH(128),
        .MAX_OUTSTANDING (4),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch          (bus.slave),
        .clear_i        (clear_i),
        .trans_cnt_o    (trans_cnt_o),
        .err_cnt_o      (err_cnt_o),
        .err_o          (err_o),
        .err_code_o     (err_code_o),
        .last_err_addr_o(last_err_addr_o),
        .outstanding_o  (outstanding_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] pat(input logic [31:0] a);
        return {a + 32'd12, a + 32'd8, a + 32'd4, a};
    endfunction

    task automatic drive(input logic req, input logic gnt, input logic [31:0] addr,
                         input logic rv, input logic [127:0] rd);
        bus.fetch_req_i    = req;
        bus.fetch_gnt_i    = gnt;
        bus.fetch_addr_i   = addr;
        bus.fetch_rvalid_i = rv;
        bus.fetch_rdata_i  = rd;
        tick();
        bus.fetch_req_i    = 1'b0;
        bus.fetch_gnt_i    = 1'b0;
        bus.fetch_addr_i   = '0;
        bus.fetch_rvalid_i = 1'b0;
        bus.fetch_rdata_i  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 0, '0);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_i = 1'b0;
        bus.fetch_req_i = 1'b0;
        bus.fetch_gnt_i = 1'b0;
        bus.fetch_addr_i = '0;
        bus.fetch_rvalid_i = 1'b0;
        bus.fetch_rdata_i = '0;
        repeat (3) tick();
        check("rst_trans", trans_cnt_o, 0);
        check("rst_errcnt", err_cnt_o, 0);
        check("rst_err", err_o, 0);
        check("rst_code", err_code_o, 0);
        check("rst_lastaddr", last_err_addr_o, 0);
        check("rst_occ", outstanding_o, 0);
        rst_n = 1'b1;
        tick();

        // single fetch, correct data
        drive(1, 1, 32'h0000_0120, 0, '0);
        check("t1_occ1", outstanding_o, 1);
        idle(2);
        drive(0, 0, 32'h0, 1, 128'h0000012C_00000128_00000124_00000120);
        check("t1_occ0", outstanding_o, 0);
        check("t1_trans", trans_cnt_o, 1);
        check("t1_err", err_o, 0);

        // data mismatch in word 2
        pulse_clear();
        check("clr_trans", trans_cnt_o, 0);
        drive(1, 1, 32'h0000_0120, 0, '0);
        idle(2);
        drive(0, 0, 32'h0, 1, 128'h0000012C_DEADBEEF_00000124_00000120);
        check("t2_err", err_o, 1);
        check("t2_code", err_code_o, 1);
        check("t2_lastaddr", last_err_addr_o, 32'h120);
        check("t2_errcnt", err_cnt_o, 1);
        check("t2_trans", trans_cnt_o, 1);

        // overflow: fifth grant dropped, then push+pop while full is legal
        pulse_clear();
        for (int i = 0; i < 5; i++) drive(1, 1, 32'(i * 16), 0, '0);
        check("t3_code", err_code_o, 3);
        check("t3_occ", outstanding_o, 4);
        check("t3_errcnt", err_cnt_o, 1);
        drive(1, 1, 32'h50, 1, pat(32'h0));
        check("t3_pp_errcnt", err_cnt_o, 1);
        check("t3_pp_occ", outstanding_o, 4);
        drive(0, 0, 32'h0, 1, pat(32'h10));
        drive(0, 0, 32'h0, 1, pat(32'h20));
        drive(0, 0, 32'h0, 1, pat(32'h30));
        drive(0, 0, 32'h0, 1, pat(32'h50));
        check("t3_drain_errcnt", err_cnt_o, 1);
        check("t3_drain_trans", trans_cnt_o, 5);
        check("t3_drain_occ", outstanding_o, 0);

        // spurious response, then clear
        pulse_clear();
        drive(0, 0, 32'h0, 1, '0);
        check("t4_code", err_code_o, 2);
        check("t4_err", err_o, 1);
        pulse_clear();
        check("t4_clr_code", err_code_o, 0);
        check("t4_clr_err", err_o, 0);
        check("t4_clr_errcnt", err_cnt_o, 0);
        check("t4_clr_trans", trans_cnt_o, 0);
        check("t4_clr_lastaddr", last_err_addr_o, 0);

        // legal held request then grant, back-to-back responses
        drive(1, 0, 32'h400, 0, '0);
        drive(1, 1, 32'h400, 0, '0);
        drive(1, 1, 32'h410, 1, pat(32'h400));
        drive(1, 1, 32'h420, 1, pat(32'h410));
        drive(0, 0, 32'h0, 1, pat(32'h420));
        check("t5_err", err_o, 0);
        check("t5_trans", trans_cnt_o, 3);
        check("t5_occ", outstanding_o, 0);

        // request drop, and address change while pending
        drive(1, 0, 32'h200, 0, '0);
        drive(1, 0, 32'h200, 0, '0);
        check("t6_nodrop", err_o, 0);
        drive(0, 0, 32'h0, 0, '0);
        check("t6_code", err_code_o, 5);
        pulse_clear();
        drive(1, 0, 32'h300, 0, '0);
        drive(1, 0, 32'h310, 0, '0);
        check("t6b_code", err_code_o, 5);
        drive(0, 0, 32'h0, 0, '0);
        check("t6b_errcnt", err_cnt_o, 1);

        // watchdog
        pulse_clear();
        drive(1, 1, 32'h500, 0, '0);
`ifdef FETCH_CHK_TIMEOUT_EN
        idle(20);
        check("t7_code", err_code_o, 4);
`else
        idle(1000);
        check("t7_err", err_o, 0);
`endif
        drive(0, 0, 32'h0, 1, pat(32'h500));
        check("t7_occ", outstanding_o, 0);

        // asynchronous reset mid-transaction
        drive(1, 1, 32'h600, 0, '0);
        #2 rst_n = 1'b0;
        #1;
        check("t8_rst_occ", outstanding_o, 0);
        check("t8_rst_trans", trans_cnt_o, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
